rmii_phy_rx: RTL

//  PHY-side receiver for frames the MAC transmits on RMII (rmii_txen/rmii_txd).

---
 rtl/rmii_phy_rx_pkg.sv | 32 +++
 rtl/rmii_phy_rx_if.sv | 26 ++
 rtl/rmii_phy_rx_crc32.sv | 28 ++
 rtl/rmii_phy_rx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/rmii_phy_rx_pkg.sv
// Shared constants, state type and CRC helpers for the RMII PHY-side receiver.
package rmii_phy_rx_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [1:0]  PRE_DIBIT   = 2'b01;
    localparam logic [1:0]  SFD_DIBIT   = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        DROP = 3'd4
    } rmii_rx_state_e;

    // Reflected CRC-32 advanced by one byte, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] din);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/rmii_phy_rx_if.sv
// Bundle of the RMII transmit-side inputs and the receiver's byte stream/status outputs.
interface rmii_phy_rx_if;

    logic        rmii_txen;
    logic [1:0]  rmii_txd;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_sof;
    logic        frm_done;
    logic [10:0] frm_len;
    logic        frm_crc_ok;
    logic [3:0]  frm_err;
    logic [15:0] cnt_ok;
    logic [15:0] cnt_bad;

    modport master (
        output rmii_txen, rmii_txd,
        input  rx_valid, rx_data, rx_sof, frm_done, frm_len, frm_crc_ok, frm_err, cnt_ok, cnt_bad
    );

    modport slave (
        input  rmii_txen, rmii_txd,
        output rx_valid, rx_data, rx_sof, frm_done, frm_len, frm_crc_ok, frm_err, cnt_ok, cnt_bad
    );

endinterface

// File: rtl/rmii_phy_rx_crc32.sv
// Byte-wise CRC-32 register; init has priority over a byte update.
module rmii_phy_rx_crc32
    import rmii_phy_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] crc
);

    logic [31:0] crc_r;

    // Running CRC over every byte after the SFD
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            crc_r <= CRC_INIT;
        end else if (init) begin
            crc_r <= CRC_INIT;
        end else if (en) begin
            crc_r <= crc32_byte(crc_r, din);
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/rmii_phy_rx.sv
// RMII PHY-side receiver: strips preamble/SFD, rebuilds bytes from dibits,
// checks and removes the FCS, and reports per-frame status and counters.
module rmii_phy_rx
    import rmii_phy_rx_pkg::*;
#(
    parameter int MIN_PRE = 4,
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514
) (
    input  logic         clk,
    input  logic         rstn,
    rmii_phy_rx_if.slave bus
);

    localparam logic [7:0]  MIN_PRE_C = 8'(MIN_PRE);
    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);

    rmii_rx_state_e  state_r;
    logic [7:0]      pre_cnt_r;
    logic [1:0]      phase_r;
    logic [5:0]      sh_r;
    logic [3:0][7:0] pipe_r;
    logic [2:0]      pipe_cnt_r;
    logic [10:0]     len_r;
    logic            sof_pend_r;

    logic            rx_valid_r;
    logic [7:0]      rx_data_r;
    logic            rx_sof_r;
    logic            frm_done_r;
    logic [10:0]     frm_len_r;
    logic            frm_crc_ok_r;
    logic [3:0]      frm_err_r;
    logic [15:0]     cnt_ok_r;
    logic [15:0]     cnt_bad_r;

    logic            txen_s;
    logic [1:0]      txd_s;
    logic [7:0]      byte_s;
    logic            sfd_s;
    logic            byte_done_s;
    logic [31:0]     crc_s;
    logic            crc_ok_s;
    logic [3:0]      err_s;
    logic            good_s;

    assign txen_s      = bus.rmii_txen;
    assign txd_s       = bus.rmii_txd;
    assign byte_s      = {txd_s, sh_r};
    assign sfd_s       = (state_r == PRE) && txen_s && (txd_s == SFD_DIBIT) && (pre_cnt_r >= MIN_PRE_C);
    assign byte_done_s = (state_r == DATA) && txen_s && (phase_r == 2'd3);

    rmii_phy_rx_crc32 u_crc (
        .clk  (clk),
        .rstn (rstn),
        .init (sfd_s),
        .en   (byte_done_s),
        .din  (byte_s),
        .crc  (crc_s)
    );

    // Frame status as it would be reported if txen is seen low this cycle
    always_comb begin
        err_s    = {(phase_r != 2'd0), (len_r > MAX_LEN_C), (len_r < MIN_LEN_C), 1'b0};
        crc_ok_s = (crc_s == CRC_RESIDUE);
        good_s   = crc_ok_s && (err_s == 4'b0000);
    end

    // Receive FSM with dibit shifter, 4-byte FCS hold-back pipe and status registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= IDLE;
            pre_cnt_r    <= 8'd0;
            phase_r      <= 2'd0;
            sh_r         <= 6'd0;
            pipe_r       <= 32'd0;
            pipe_cnt_r   <= 3'd0;
            len_r        <= 11'd0;
            sof_pend_r   <= 1'b0;
            rx_valid_r   <= 1'b0;
            rx_data_r    <= 8'd0;
            rx_sof_r     <= 1'b0;
            frm_done_r   <= 1'b0;
            frm_len_r    <= 11'd0;
            frm_crc_ok_r <= 1'b0;
            frm_err_r    <= 4'd0;
            cnt_ok_r     <= 16'd0;
            cnt_bad_r    <= 16'd0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_sof_r   <= 1'b0;
            frm_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (txen_s) begin
                        if (txd_s == PRE_DIBIT) begin
                            state_r   <= PRE;
                            pre_cnt_r <= 8'd1;
                        end else begin
                            state_r <= DROP;
                        end
                    end
                end
                PRE: begin
                    if (!txen_s) begin
                        state_r <= IDLE;
                    end else if (txd_s == PRE_DIBIT) begin
                        if (pre_cnt_r != 8'hFF) begin
                            pre_cnt_r <= pre_cnt_r + 8'd1;
                        end
                    end else if (sfd_s) begin
                        state_r    <= DATA;
                        phase_r    <= 2'd0;
                        pipe_cnt_r <= 3'd0;
                        len_r      <= 11'd0;
                        sof_pend_r <= 1'b1;
                    end else begin
                        state_r <= DROP;
                    end
                end
                DATA: begin
                    if (!txen_s) begin
                        state_r      <= DONE;
                        frm_done_r   <= 1'b1;
                        frm_len_r    <= len_r;
                        frm_crc_ok_r <= crc_ok_s;
                        frm_err_r    <= err_s;
                        if (good_s) begin
                            cnt_ok_r <= sat_inc16(cnt_ok_r);
                        end else begin
                            cnt_bad_r <= sat_inc16(cnt_bad_r);
                        end
                    end else begin
                        phase_r <= phase_r + 2'd1;
                        sh_r    <= {txd_s, sh_r[5:2]};
                        if (byte_done_s) begin
                            // The last four bytes are always the FCS, so only bytes pushed
                            // out of a full pipe are payload
                            pipe_r <= {byte_s, pipe_r[3:1]};
                            if (pipe_cnt_r == 3'd4) begin
                                rx_valid_r <= 1'b1;
                                rx_data_r  <= pipe_r[0];
                                rx_sof_r   <= sof_pend_r;
                                sof_pend_r <= 1'b0;
                                if (len_r != 11'h7FF) begin
                                    len_r <= len_r + 11'd1;
                                end
                            end else begin
                                pipe_cnt_r <= pipe_cnt_r + 3'd1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    pipe_cnt_r <= 3'd0;
                    phase_r    <= 2'd0;
                    sof_pend_r <= 1'b0;
                end
                DROP: begin
                    if (!txen_s) begin
                        state_r      <= IDLE;
                        frm_done_r   <= 1'b1;
                        frm_len_r    <= 11'd0;
                        frm_crc_ok_r <= 1'b0;
                        frm_err_r    <= 4'b0001;
                        cnt_bad_r    <= sat_inc16(cnt_bad_r);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.rx_valid   = rx_valid_r;
    assign bus.rx_data    = rx_data_r;
    assign bus.rx_sof     = rx_sof_r;
    assign bus.frm_done   = frm_done_r;
    assign bus.frm_len    = frm_len_r;
    assign bus.frm_crc_ok = frm_crc_ok_r;
    assign bus.frm_err    = frm_err_r;
    assign bus.cnt_ok     = cnt_ok_r;
    assign bus.cnt_bad    = cnt_bad_r;

endmodule
